run_bit_packer: RTL and testbench
=================================

Name: run_bit_packer

Overview:
- Sits directly downstream of the run-mode coder.
- Consumes its per-pixel code-field bundle (oc, pv/pc, zc, bv/bc) and serialises the fields MSB-first into a contiguous bitstream.
- Emits the bitstream as fixed-width words to the byte-stuffing/marker stage.
- Upstream has no backpressure, so the block accepts one bundle every cycle and never stalls.

Parameters:
OW, 128, output word width in bits; must be a power of two and >= 96 (max bits per bundle is 92).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_vl  in  1  bundle valid
i_oc  in  5  number of '1' bits (run segment marks)
i_pv  in  15  run payload value; low i_pc bits used
i_pc  in  4  run payload bit count (0..15)
i_zc  in  5  unary field: 0 = nothing, n>=1 = (n-1) '0' bits then one '1'
i_bv  in  9  binary suffix value; zero-extended, low i_bc bits used
i_bc  in  4  binary suffix bit count (0..15)
i_flush  in  1  end of image; sampled with or without i_vl, applied after that cycle's bundle
o_vl  out  1  word valid
o_data  out  OW  packed bits; first bit in o_data[OW-1]
o_nbits  out  $clog2(OW)+1  valid bits in o_data (OW except on a last word)
o_last  out  1  final word of image
o_err  out  1  sticky protocol-violation flag

Behaviour:
- Bit order per bundle: oc ones, then pv[pc-1:0], then the zc field, then bv[bc-1:0] (zero-extended to 15 bits).
- Bundle length L = oc + pc + zc + bc, range 0..92.
- A bundle with L=0, including when i_vl=0, changes no state.
- Stage S1 (registered):
  - Builds a 96-bit left-justified code plus a 7-bit L from the input fields.
  - Registers i_flush alongside.
- Stage S2 (registered):
  - Accumulator of 2*OW bits with count register cnt (0..OW-1 between cycles).
  - Appends the code at bit position cnt from the MSB, giving t = cnt + L.
  - If t >= OW: o_vl=1, o_data = top OW bits, o_nbits = OW, o_last=0; the remainder shifts to the top and cnt = t - OW.
  - Else: cnt = t and o_vl=0.
- Latency: the word completed by a bundle appears on the outputs 2 cycles after that bundle's i_vl cycle.
- Throughput: 1 bundle per cycle sustained. Since 92 < OW, at most one full word forms per merge, so the accumulator never overflows.
- Flush state machine, states RUN and FLUSH2:
  - RUN, S2 sees flush with t < OW: emit o_data = accumulator padded with zeros, o_nbits = t, o_last=1. This includes t = 0, which gives o_nbits = 0 and data all zeros. Then cnt = 0 and stay in RUN.
  - RUN, S2 sees flush with t >= OW: emit the full word (o_last=0) and go to FLUSH2.
  - FLUSH2: next cycle emit the remainder zero-padded, o_nbits = t - OW, o_last=1, cnt = 0, return to RUN.
- Protocol rule: no i_vl or i_flush during the 2 input cycles following an i_flush cycle.
  - A violating bundle or flush that reaches S2 while the FSM is in FLUSH2 is dropped.
  - o_err is set and stays set until rst.
- Outputs are registered. Reset values: o_vl=0, o_data=0, o_nbits=0, o_last=0, o_err=0, cnt=0, FSM=RUN, S1 valid/flush=0.
- o_data/o_nbits hold their last value when o_vl=0; the checker samples them only on o_vl.
- Reset mid-operation: the next cycle behaves as after power-up. Partially accumulated bits and in-flight S1 content are discarded, and no word is emitted for them.
- Arithmetic: L is computed in 7 bits and t in $clog2(OW)+1 bits; neither ever wraps.

Test Plan:
- Single bundle oc=3, pc=2, pv=2, zc=1, bc=0, then i_flush next cycle -> one word with o_data[127:122]=6'b111101, rest 0, o_nbits=6, o_last=1.
- i_flush with empty accumulator (no prior bundles) -> one word with o_data=0, o_nbits=0, o_last=1; a zc=0/oc=0/pc=0/bc=0 bundle before it must not change this.
- Two max bundles back-to-back (oc=31, pc=15, pv=0x7FFF, zc=31, bc=15, bv=0x1FF) -> first word 2 cycles after the 2nd bundle with the correct 128 bits (31 ones, 15 ones, 30 zeros, 1, 6 zeros + 9 ones, ...), cnt=56 afterwards.
- Same two bundles with i_flush on the second -> full word (o_last=0, o_nbits=128) then next cycle a word with o_nbits=56, o_last=1, correct remainder.
- Random bundles for 10k cycles vs a golden bit-queue model, including flushes and assertion of rst mid-stream -> bit-exact words; after rst no stale bits appear.
- i_vl bundle one cycle after a flush that enters FLUSH2 -> bundle dropped, o_err=1 and stays 1 until rst; the flush word sequence is unaltered.

Source files
------------

// File: rtl/run_bit_packer.sv
// Packs run-mode code-field bundles MSB-first into a contiguous bitstream and
// emits it as OW-bit words; two register stages, one bundle per cycle, no stall.
module run_bit_packer #(
    parameter int OW = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vl,
    input  logic [4:0]            i_oc,
    input  logic [14:0]           i_pv,
    input  logic [3:0]            i_pc,
    input  logic [4:0]            i_zc,
    input  logic [8:0]            i_bv,
    input  logic [3:0]            i_bc,
    input  logic                  i_flush,
    output logic                  o_vl,
    output logic [OW-1:0]         o_data,
    output logic [$clog2(OW):0]   o_nbits,
    output logic                  o_last,
    output logic                  o_err
);

    localparam int NB = $clog2(OW) + 1;
    localparam int CW = 96;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH2
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: left-justified code word and bundle length
    // ------------------------------------------------------------------
    logic [6:0]    w_len;
    logic [6:0]    w_pv_sh;
    logic [6:0]    w_zc_sh;
    logic [6:0]    w_bv_sh;
    logic [14:0]   w_pv_mask;
    logic [14:0]   w_bv_mask;
    logic [14:0]   w_pv_m;
    logic [14:0]   w_bv_m;
    logic [CW-1:0] w_ones;
    logic [CW-1:0] w_pv_field;
    logic [CW-1:0] w_zc_field;
    logic [CW-1:0] w_bv_field;
    logic [CW-1:0] w_code;

    assign w_len = {2'b00, i_oc} + {3'b000, i_pc} + {2'b00, i_zc} + {3'b000, i_bc};

    // Each field is placed so its LSB lands just above the bits that follow it.
    assign w_pv_sh = 7'd96 - {2'b00, i_oc} - {3'b000, i_pc};
    assign w_zc_sh = w_pv_sh - {2'b00, i_zc};
    assign w_bv_sh = 7'd96 - w_len;

    assign w_pv_mask = 15'((16'd1 << i_pc) - 16'd1);
    assign w_bv_mask = 15'((16'd1 << i_bc) - 16'd1);
    assign w_pv_m    = i_pv & w_pv_mask;
    assign w_bv_m    = {6'b000000, i_bv} & w_bv_mask;

    for (genvar gi = 0; gi < CW; gi++) begin : g_ones
        assign w_ones[CW-1-gi] = (7'(gi) < {2'b00, i_oc});
    end

    assign w_pv_field = {{(CW-15){1'b0}}, w_pv_m} << w_pv_sh;
    assign w_zc_field = (i_zc != 5'd0) ? ({{(CW-1){1'b0}}, 1'b1} << w_zc_sh) : '0;
    assign w_bv_field = {{(CW-15){1'b0}}, w_bv_m} << w_bv_sh;
    assign w_code     = w_ones | w_pv_field | w_zc_field | w_bv_field;

    logic [CW-1:0] r_s1_code;
    logic [6:0]    r_s1_len;
    logic          r_s1_vl;
    logic          r_s1_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_code  <= '0;
            r_s1_len   <= '0;
            r_s1_vl    <= 1'b0;
            r_s1_flush <= 1'b0;
        end else begin
            // An invalid bundle enters as an empty code so it merges as a no-op.
            r_s1_code  <= i_vl ? w_code : '0;
            r_s1_len   <= i_vl ? w_len : '0;
            r_s1_vl    <= i_vl;
            r_s1_flush <= i_flush;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulator merge, word emission and flush FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_next;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] w_acc_next;
    logic [NB-1:0] r_cnt;
    logic [NB-1:0] w_cnt_next;
    logic          r_vl;
    logic          w_vl_next;
    logic [OW-1:0] r_data;
    logic [OW-1:0] w_data_next;
    logic [NB-1:0] r_nbits;
    logic [NB-1:0] w_nbits_next;
    logic          r_last;
    logic          w_last_next;
    logic          r_err;
    logic          w_err_next;

    logic [2*OW-1:0] w_merged;
    logic [NB-1:0]   w_t;
    logic            w_full;

    // Only the upper half of the 2*OW window holds state between cycles; the
    // lower half exists only during the merge.
    assign w_merged = {r_acc, {OW{1'b0}}} | ({r_s1_code, {(2*OW-CW){1'b0}}} >> r_cnt);
    assign w_t      = r_cnt + NB'(r_s1_len);
    assign w_full   = (w_t >= NB'(OW));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_vl_next    = 1'b0;
        w_data_next  = r_data;
        w_nbits_next = r_nbits;
        w_last_next  = r_last;
        w_err_next   = r_err;

        case (r_state)
            ST_RUN: begin
                if (w_full) begin
                    w_vl_next    = 1'b1;
                    w_data_next  = w_merged[2*OW-1:OW];
                    w_nbits_next = NB'(OW);
                    w_last_next  = 1'b0;
                    w_acc_next   = w_merged[OW-1:0];
                    w_cnt_next   = w_t - NB'(OW);
                    if (r_s1_flush) begin
                        w_state_next = ST_FLUSH2;
                    end
                end else if (r_s1_flush) begin
                    // Tail word, possibly empty (nbits = 0) when nothing is pending.
                    w_vl_next    = 1'b1;
                    w_data_next  = w_merged[2*OW-1:OW];
                    w_nbits_next = w_t;
                    w_last_next  = 1'b1;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_acc_next = w_merged[2*OW-1:OW];
                    w_cnt_next = w_t;
                end
            end
            ST_FLUSH2: begin
                w_vl_next    = 1'b1;
                w_data_next  = r_acc;
                w_nbits_next = r_cnt;
                w_last_next  = 1'b1;
                w_acc_next   = '0;
                w_cnt_next   = '0;
                w_state_next = ST_RUN;
                // Anything arriving here broke the post-flush quiet window; drop it.
                if (r_s1_vl || r_s1_flush) begin
                    w_err_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_vl    <= 1'b0;
            r_data  <= '0;
            r_nbits <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_vl    <= w_vl_next;
            r_data  <= w_data_next;
            r_nbits <= w_nbits_next;
            r_last  <= w_last_next;
            r_err   <= w_err_next;
        end
    end

    assign o_vl    = r_vl;
    assign o_data  = r_data;
    assign o_nbits = r_nbits;
    assign o_last  = r_last;
    assign o_err   = r_err;

endmodule

// File: tb/tb_run_bit_packer.sv
// Scoreboard bench for run_bit_packer: directed vectors with hand-built words,
// then a random stream checked against a bit-queue model.
module tb_run_bit_packer;

    localparam int OW = 128;
    localparam int NB = 8;

    // Two max bundles (92 bits each): first word and 56-bit remainder.
    localparam logic [OW-1:0] W_MAX1 = {{46{1'b1}}, {30{1'b0}}, 1'b1, {6{1'b0}}, {9{1'b1}}, {36{1'b1}}};
    localparam logic [OW-1:0] R_MAX1 = {{10{1'b1}}, {30{1'b0}}, 1'b1, {6{1'b0}}, {9{1'b1}}, {72{1'b0}}};
    localparam logic [OW-1:0] W_T1   = {6'b111101, {122{1'b0}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_vl = 1'b0;
    logic [4:0]    i_oc = '0;
    logic [14:0]   i_pv = '0;
    logic [3:0]    i_pc = '0;
    logic [4:0]    i_zc = '0;
    logic [8:0]    i_bv = '0;
    logic [3:0]    i_bc = '0;
    logic          i_flush = 1'b0;
    logic          o_vl;
    logic [OW-1:0] o_data;
    logic [NB-1:0] o_nbits;
    logic          o_last;
    logic          o_err;

    run_bit_packer #(.OW(OW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_vl    (i_vl),
        .i_oc    (i_oc),
        .i_pv    (i_pv),
        .i_pc    (i_pc),
        .i_zc    (i_zc),
        .i_bv    (i_bv),
        .i_bc    (i_bc),
        .i_flush (i_flush),
        .o_vl    (o_vl),
        .o_data  (o_data),
        .o_nbits (o_nbits),
        .o_last  (o_last),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] data;
        int            nbits;
        bit            last;
        int            at;
    } exp_t;

    exp_t expq[$];
    bit   bq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t mon_e;

    task automatic push_exp(input logic [OW-1:0] d, input int nb, input bit l, input int at);
        exp_t e;
        e.data  = d;
        e.nbits = nb;
        e.last  = l;
        e.at    = at;
        expq.push_back(e);
    endtask

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every presented word must match the head of the queue, on time.
    always @(negedge clk) begin
        if (o_vl === 1'b1) begin
            n_chk++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: cyc=%0d data=%h nbits=%0d last=%0b, required no word",
                         cyc, o_data, o_nbits, o_last);
            end else begin
                mon_e = expq.pop_front();
                if (o_data !== mon_e.data || o_nbits !== NB'(mon_e.nbits) ||
                    o_last !== mon_e.last || cyc != mon_e.at) begin
                    n_fail++;
                    $display("FAIL word: cyc=%0d data=%h nbits=%0d last=%0b, required cyc=%0d data=%h nbits=%0d last=%0b",
                             cyc, o_data, o_nbits, o_last, mon_e.at, mon_e.data, mon_e.nbits, mon_e.last);
                end else begin
                    $display("word cyc=%0d nbits=%0d last=%0b data=%h ok", cyc, o_nbits, o_last, o_data);
                end
            end
        end
    end

    // Golden model: serialise to individual bits, cut words from the queue.
    task automatic model_step(input bit vl, input logic [4:0] oc, input logic [14:0] pv,
                              input logic [3:0] pc, input logic [4:0] zc, input logic [8:0] bv,
                              input logic [3:0] bc, input bit fl);
        logic [OW-1:0] d;
        bit full = 1'b0;
        int n;
        if (vl) begin
            for (int i = 0; i < int'(oc); i++) bq.push_back(1'b1);
            for (int i = int'(pc) - 1; i >= 0; i--) bq.push_back(pv[i]);
            if (zc != 0) begin
                for (int i = 1; i < int'(zc); i++) bq.push_back(1'b0);
                bq.push_back(1'b1);
            end
            for (int i = int'(bc) - 1; i >= 0; i--) bq.push_back((i < 9) ? bv[i] : 1'b0);
        end
        if (bq.size() >= OW) begin
            d = '0;
            for (int i = 0; i < OW; i++) d[OW-1-i] = bq.pop_front();
            push_exp(d, OW, 1'b0, cyc + 2);
            full = 1'b1;
        end
        if (fl) begin
            n = bq.size();
            d = '0;
            for (int i = 0; i < n; i++) d[OW-1-i] = bq.pop_front();
            push_exp(d, n, 1'b1, cyc + (full ? 3 : 2));
        end
    endtask

    task automatic drive(input bit vl, input logic [4:0] oc, input logic [14:0] pv,
                         input logic [3:0] pc, input logic [4:0] zc, input logic [8:0] bv,
                         input logic [3:0] bc, input bit fl, input bit mdl);
        i_vl = vl; i_oc = oc; i_pv = pv; i_pc = pc;
        i_zc = zc; i_bv = bv; i_bc = bc; i_flush = fl;
        if (mdl) model_step(vl, oc, pv, pc, zc, bv, bc, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drive_max(input bit fl);
        drive(1'b1, 5'd31, 15'h7FFF, 4'd15, 5'd31, 9'h1FF, 4'd15, fl, 1'b0);
    endtask

    // Words the reset edge would have produced are never emitted.
    task automatic do_reset(input int n);
        i_vl = 1'b0; i_flush = 1'b0;
        rst = 1'b1;
        while (expq.size() > 0 && expq[expq.size()-1].at >= cyc + 1) void'(expq.pop_back());
        bq.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_o_vl",    OW'(o_vl),    '0);
        check("reset_o_data",  o_data,       '0);
        check("reset_o_nbits", OW'(o_nbits), '0);
        check("reset_o_last",  OW'(o_last),  '0);
        check("reset_o_err",   OW'(o_err),   '0);

        // Short bundle then flush: 111 10 1
        drive(1'b1, 5'd3, 15'd2, 4'd2, 5'd1, 9'd0, 4'd0, 1'b0, 1'b0);
        push_exp(W_T1, 6, 1'b1, cyc + 2);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Empty bundle then flush on empty accumulator
        drive(1'b1, 5'd0, 15'h1234, 4'd0, 5'd0, 9'h0AB, 4'd0, 1'b0, 1'b0);
        push_exp('0, 0, 1'b1, cyc + 2);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Two max bundles, separate flush later
        drive_max(1'b0);
        push_exp(W_MAX1, OW, 1'b0, cyc + 2);
        drive_max(1'b0);
        idle(1);
        push_exp(R_MAX1, 56, 1'b1, cyc + 2);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Two max bundles, flush on the second
        drive_max(1'b0);
        push_exp(W_MAX1, OW, 1'b0, cyc + 2);
        push_exp(R_MAX1, 56, 1'b1, cyc + 3);
        drive_max(1'b1);
        idle(3);
        check("err_clear_before_violation", OW'(o_err), '0);

        // Protocol violation: bundle right after a flush entering FLUSH2
        drive_max(1'b0);
        push_exp(W_MAX1, OW, 1'b0, cyc + 2);
        push_exp(R_MAX1, 56, 1'b1, cyc + 3);
        drive_max(1'b1);
        drive(1'b1, 5'd7, 15'd0, 4'd0, 5'd1, 9'd0, 4'd0, 1'b0, 1'b0);
        idle(3);
        check("err_set", OW'(o_err), OW'(1));
        push_exp('0, 0, 1'b1, cyc + 2);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(5);
        check("err_sticky", OW'(o_err), OW'(1));
        do_reset(2);
        check("err_cleared_by_rst", OW'(o_err), '0);

        // Reset with bits accumulated and a bundle in flight
        drive_max(1'b0);
        drive_max(1'b0);
        do_reset(1);
        push_exp('0, 0, 1'b1, cyc + 2);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Random stream against the bit-queue model
        for (int n = 0; n < 10000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset(1);
            end else if (r < 30) begin
                drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 15'($urandom),
                      4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 9'($urandom),
                      4'($urandom_range(0, 15)), 1'b1, 1'b1);
                drive(1'b0, 5'($urandom), 15'($urandom), 4'($urandom), 5'($urandom), 9'($urandom),
                      4'($urandom), 1'b0, 1'b1);
                drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
            end else begin
                drive($urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), 15'($urandom),
                      4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 9'($urandom),
                      4'($urandom_range(0, 15)), 1'b0, 1'b1);
            end
        end
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
        idle(6);

        check("scoreboard_drained", OW'(expq.size()), '0);
        check("err_clear_after_random", OW'(o_err), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
